mem_responder: RTL and testbench

- Memory-side responder for the core's MEM_* request bus: the slave that mem_controller drives.
- Word-organised synchronous RAM with byte/halfword/word lanes and a programmable response latency.
- Accepts one command at a time via MEM_Ready/MEM_Cmd and acknowledges every command, read or write, with a one-cycle MEM_DataReady pulse.
- Instantiated in the SoC as data memory behind mem_controller.

---
 rtl/soc_mem_pkg.sv | 41 ++++
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_lane_array.sv | 25 ++
 rtl/mem_responder.sv | 147 ++++++++++++++
 tb/tb_mem_responder.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/soc_mem_pkg.sv
// Shared encodings and lane helpers for the MEM_* request bus.
// Sizes match MEM_ByteEnable; 2'b10 is reserved and always faults.
package soc_mem_pkg;

  localparam logic [1:0] MEM_SZ_BYTE = 2'b00;
  localparam logic [1:0] MEM_SZ_HALF = 2'b01;
  localparam logic [1:0] MEM_SZ_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_e;

  // Byte write strobes for a size/lane pair; reserved size yields no strobes.
  function automatic logic [3:0] mem_wstrb(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] strb;
    case (size)
      MEM_SZ_BYTE: strb = 4'b0001 << lane;
      MEM_SZ_HALF: strb = lane[1] ? 4'b1100 : 4'b0011;
      MEM_SZ_WORD: strb = 4'b1111;
      default:     strb = 4'b0000;
    endcase
    return strb;
  endfunction

  // Right-justify and zero-extend the addressed lane of a RAM word.
  function automatic logic [31:0] mem_rd_steer(input logic [1:0] size, input logic [1:0] lane,
                                               input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {lane, 3'b000};
    case (size)
      MEM_SZ_BYTE: res = {24'b0, sh[7:0]};
      MEM_SZ_HALF: res = {16'b0, sh[15:0]};
      default:     res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// MEM_* request bus between mem_controller (master) and a memory responder (slave).
interface mem_responder_if;

  logic        MEM_Ready;
  logic        MEM_Cmd;
  logic        MEM_We;
  logic [1:0]  MEM_ByteEnable;
  logic [31:0] MEM_Addr;
  logic [31:0] MEM_InData;
  logic [31:0] MEM_OutData;
  logic        MEM_DataReady;
  logic        MEM_Error;

  modport master (
    input  MEM_Ready, MEM_OutData, MEM_DataReady, MEM_Error,
    output MEM_Cmd, MEM_We, MEM_ByteEnable, MEM_Addr, MEM_InData
  );

  modport slave (
    output MEM_Ready, MEM_OutData, MEM_DataReady, MEM_Error,
    input  MEM_Cmd, MEM_We, MEM_ByteEnable, MEM_Addr, MEM_InData
  );

endinterface

// File: rtl/mem_lane_array.sv
// Word-organised RAM with per-byte write enables and a registered read port.
module mem_lane_array #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter string       INIT_FILE  = ""
) (
  input  logic                  Clk,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [31:0] mem [Depth];

  always_ff @(posedge Clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the MEM_* bus: one command at a time, fixed response latency,
// byte/halfword/word lanes, and a DataReady pulse (with Error on faults) for every command.
module mem_responder
  import soc_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned LATENCY    = 1,
  parameter string       INIT_FILE  = ""
) (
  input  logic            Clk,
  input  logic            Reset,
  mem_responder_if.slave  bus
);

  mem_state_e state_q, state_d;

  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        drdy_q, drdy_d;
  logic        err_q, err_d;
  logic [31:0] odata_q, odata_d;

  logic        we_q;
  logic [1:0]  size_q;
  logic [31:0] off_q;
  logic [31:0] wdata_q;

  logic                  accept;
  logic                  commit;
  logic                  in_range;
  logic                  fault;
  logic [1:0]            lane;
  logic [ADDR_WIDTH-1:0] widx_in;
  logic [ADDR_WIDTH-1:0] widx_q;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [3:0]            ram_we;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_rdata;

  // Ready low in IDLE marks the post-reset cycle and the DataReady pulse cycle.
  assign accept = (state_q == IDLE) && ready_q && bus.MEM_Cmd;
  // The response edge is the one that leaves RESP.
  assign commit = (state_q == RESP);

  assign widx_in  = ADDR_WIDTH'((bus.MEM_Addr - BASE_ADDR) >> 2);
  assign widx_q   = ADDR_WIDTH'(off_q >> 2);
  assign lane     = off_q[1:0];
  assign in_range = (off_q >> (ADDR_WIDTH + 2)) == 32'd0;
  assign fault    = !in_range
                 || (size_q == 2'b10)
                 || ((size_q == MEM_SZ_HALF) && lane[0])
                 || ((size_q == MEM_SZ_WORD) && (lane != 2'b00));

  // Present the incoming index while idle so LATENCY=1 reads have data at the response edge.
  assign raddr  = (state_q == IDLE) ? widx_in : widx_q;
  assign ram_we = (commit && we_q && !fault && !Reset) ? mem_wstrb(size_q, lane) : 4'b0000;

  always_comb begin
    ram_wdata = wdata_q;
    case (size_q)
      MEM_SZ_BYTE: ram_wdata = {4{wdata_q[7:0]}};
      MEM_SZ_HALF: ram_wdata = {2{wdata_q[15:0]}};
      default:     ram_wdata = wdata_q;
    endcase
  end

  mem_lane_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_array (
    .Clk   (Clk),
    .we    (ram_we),
    .waddr (widx_q),
    .wdata (ram_wdata),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt_q == 4'd1) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_d = 1'b0;
    drdy_d  = 1'b0;
    err_d   = 1'b0;
    odata_d = odata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        ready_d = !accept;
        if (accept) cnt_d = 4'(LATENCY - 1);
      end
      WAIT: cnt_d = cnt_q - 4'd1;
      RESP: begin
        drdy_d = 1'b1;
        err_d  = fault;
        if (!we_q) odata_d = fault ? 32'd0 : mem_rd_steer(size_q, lane, ram_rdata);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ready_q <= 1'b0;
      drdy_q  <= 1'b0;
      err_q   <= 1'b0;
      odata_q <= 32'd0;
      cnt_q   <= 4'd0;
    end else begin
      ready_q <= ready_d;
      drdy_q  <= drdy_d;
      err_q   <= err_d;
      odata_q <= odata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Command holding registers; contents only matter while a command is in flight.
  always_ff @(posedge Clk) begin
    if (accept) begin
      we_q    <= bus.MEM_We;
      size_q  <= bus.MEM_ByteEnable;
      off_q   <= bus.MEM_Addr - BASE_ADDR;
      wdata_q <= bus.MEM_InData;
    end
  end

  assign bus.MEM_Ready     = ready_q;
  assign bus.MEM_DataReady = drdy_q;
  assign bus.MEM_Error     = err_q;
  assign bus.MEM_OutData   = odata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: LATENCY=1 and LATENCY=4 instances, scoreboard of expected responses.
module tb_mem_responder;
  import soc_mem_pkg::*;

  typedef struct packed {
    logic        err;
    logic [31:0] out;
  } exp_t;

  logic        clk = 1'b0;
  logic [1:0]  rst_v;
  logic [1:0]  cmd_v;
  logic        we;
  logic [1:0]  be;
  logic [31:0] addr;
  logic [31:0] indata;

  always #5 clk = ~clk;

  mem_responder_if bus_a ();
  mem_responder_if bus_b ();

  assign bus_a.MEM_Cmd        = cmd_v[0];
  assign bus_a.MEM_We         = we;
  assign bus_a.MEM_ByteEnable = be;
  assign bus_a.MEM_Addr       = addr;
  assign bus_a.MEM_InData     = indata;
  assign bus_b.MEM_Cmd        = cmd_v[1];
  assign bus_b.MEM_We         = we;
  assign bus_b.MEM_ByteEnable = be;
  assign bus_b.MEM_Addr       = addr;
  assign bus_b.MEM_InData     = indata;

  mem_responder #(.LATENCY(1)) u_dut_a (.Clk(clk), .Reset(rst_v[0]), .bus(bus_a));
  mem_responder #(.LATENCY(4)) u_dut_b (.Clk(clk), .Reset(rst_v[1]), .bus(bus_b));

  logic [1:0]        rdy_v, drdy_v, err_v;
  logic [1:0][31:0]  out_v;
  assign rdy_v  = {bus_b.MEM_Ready, bus_a.MEM_Ready};
  assign drdy_v = {bus_b.MEM_DataReady, bus_a.MEM_DataReady};
  assign err_v  = {bus_b.MEM_Error, bus_a.MEM_Error};
  assign out_v  = {bus_b.MEM_OutData, bus_a.MEM_OutData};

  exp_t        q_a[$];
  exp_t        q_b[$];
  exp_t        e_m;
  int          n_checks = 0;
  int          n_errs   = 0;
  logic [31:0] last_out [2];
  logic [31:0] model [8];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int latency(input int s);
    return (s == 0) ? 1 : 4;
  endfunction

  // Scoreboard: every DataReady pulse must match the oldest pending expectation.
  always @(posedge clk) begin
    #1;
    for (int s = 0; s < 2; s++) begin
      if (drdy_v[s]) begin
        if ((s == 0 && q_a.size() == 0) || (s == 1 && q_b.size() == 0)) begin
          check("spurious_pulse", 32'(drdy_v[s]), 32'd0);
        end else begin
          if (s == 0) e_m = q_a.pop_front();
          else        e_m = q_b.pop_front();
          check("resp_err", 32'(err_v[s]), 32'(e_m.err));
          check("resp_data", out_v[s], e_m.out);
        end
      end else if (err_v[s]) begin
        check("err_without_ready", 32'(err_v[s]), 32'd0);
      end
    end
  end

  task automatic xact(input int s, input logic w, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d, input logic e_err, input logic [31:0] e_rd);
    int   n;
    int   lat;
    exp_t e;
    n = 0;
    while (!rdy_v[s] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("ready_before_cmd", 32'(rdy_v[s]), 32'd1);
    if (!w) last_out[s] = e_err ? 32'd0 : e_rd;
    e.err = e_err;
    e.out = last_out[s];
    if (s == 0) q_a.push_back(e);
    else        q_b.push_back(e);
    we = w; be = sz; addr = a; indata = d; cmd_v[s] = 1'b1;
    @(posedge clk); #1;
    cmd_v[s] = 1'b0;
    check("ready_drop", 32'(rdy_v[s]), 32'd0);
    lat = 0;
    while (!drdy_v[s] && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", 32'(lat), 32'(latency(s)));
    n = 0;
    while (!rdy_v[s] && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("ready_return", 32'(n), 32'd1);
  endtask

  initial begin
    int          pulses;
    int          prev;
    int          n;
    logic [31:0] d;
    logic [31:0] a;
    logic [31:0] exp_rd;
    logic [1:0]  sz;
    logic [1:0]  ln;
    logic [2:0]  wi;
    logic        w;
    logic        flt;

    rst_v = 2'b11; cmd_v = 2'b00; we = 1'b0; be = 2'b00; addr = '0; indata = '0;
    last_out[0] = '0; last_out[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check("rst_ready", 32'(rdy_v[s]), 32'd0);
      check("rst_drdy", 32'(drdy_v[s]), 32'd0);
      check("rst_err", 32'(err_v[s]), 32'd0);
      check("rst_out", out_v[s], 32'd0);
    end
    rst_v = 2'b00;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) check("ready_after_rst", 32'(rdy_v[s]), 32'd1);

    // LATENCY=1 instance: directed lane and fault cases.
    xact(0, 1'b1, MEM_SZ_WORD, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    xact(0, 1'b0, MEM_SZ_WORD, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    xact(0, 1'b1, MEM_SZ_WORD, 32'h10, 32'h11223344, 1'b0, 32'h0);
    xact(0, 1'b1, MEM_SZ_BYTE, 32'h13, 32'hFFFFFF5A, 1'b0, 32'h0);
    xact(0, 1'b0, MEM_SZ_WORD, 32'h10, 32'h0, 1'b0, 32'h5A223344);
    xact(0, 1'b0, MEM_SZ_HALF, 32'h12, 32'h0, 1'b0, 32'h00005A22);
    xact(0, 1'b1, MEM_SZ_HALF, 32'h11, 32'h0000FFFF, 1'b1, 32'h0);
    xact(0, 1'b0, MEM_SZ_WORD, 32'h10, 32'h0, 1'b0, 32'h5A223344);
    xact(0, 1'b0, MEM_SZ_WORD, 32'h4000, 32'h0, 1'b1, 32'h0);
    xact(0, 1'b0, 2'b10, 32'h10, 32'h0, 1'b1, 32'h0);
    xact(0, 1'b1, MEM_SZ_WORD, 32'h12, 32'h0BADF00D, 1'b1, 32'h0);
    xact(0, 1'b0, MEM_SZ_BYTE, 32'h11, 32'h0, 1'b0, 32'h00000033);
    xact(0, 1'b0, MEM_SZ_WORD, 32'h10, 32'h0, 1'b0, 32'h5A223344);

    // Randomised lane traffic against a reference model over words 0x40..0x5C.
    for (int i = 0; i < 8; i++) begin
      model[i] = $urandom;
      xact(0, 1'b1, MEM_SZ_WORD, 32'h40 + 32'(4 * i), model[i], 1'b0, 32'h0);
    end
    for (int k = 0; k < 40; k++) begin
      w  = 1'($urandom_range(1));
      sz = 2'($urandom_range(3));
      ln = 2'($urandom_range(3));
      wi = 3'($urandom_range(7));
      d  = $urandom;
      a  = 32'h40 + {27'd0, wi, ln};
      flt = (sz == 2'b10) || (sz == MEM_SZ_HALF && ln[0]) || (sz == MEM_SZ_WORD && ln != 2'b00);
      exp_rd = 32'h0;
      if (!flt) begin
        if (sz == MEM_SZ_BYTE)      exp_rd = (model[wi] >> (8 * ln)) & 32'hFF;
        else if (sz == MEM_SZ_HALF) exp_rd = (model[wi] >> (16 * ln[1])) & 32'hFFFF;
        else                        exp_rd = model[wi];
        if (w) begin
          if (sz == MEM_SZ_BYTE)      model[wi][8*ln +: 8] = d[7:0];
          else if (sz == MEM_SZ_HALF) model[wi][16*ln[1] +: 16] = d[15:0];
          else                        model[wi] = d;
        end
      end
      xact(0, w, sz, a, d, flt, exp_rd);
    end

    // LATENCY=4 instance.
    xact(1, 1'b1, MEM_SZ_WORD, 32'h20, 32'h01020304, 1'b0, 32'h0);
    xact(1, 1'b0, MEM_SZ_WORD, 32'h20, 32'h0, 1'b0, 32'h01020304);

    // Cmd held high: one command per LATENCY+2 cycles, pulses at E4, E10, E16.
    last_out[1] = 32'h01020304;
    for (int k = 0; k < 3; k++) q_b.push_back('{err: 1'b0, out: 32'h01020304});
    we = 1'b0; be = MEM_SZ_WORD; addr = 32'h20; cmd_v[1] = 1'b1;
    pulses = 0; prev = 0;
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      if (i == 4) check("tput_ready_e4", 32'(rdy_v[1]), 32'd0);
      if (i == 5) check("tput_ready_e5", 32'(rdy_v[1]), 32'd1);
      if (drdy_v[1]) begin
        pulses++;
        if (pulses == 1) check("tput_first", 32'(i), 32'd4);
        else             check("tput_gap", 32'(i - prev), 32'd6);
        prev = i;
      end
    end
    cmd_v[1] = 1'b0;
    check("tput_count", 32'(pulses), 32'd3);
    n = 0;
    while (!rdy_v[1] && n < 20) begin
      @(posedge clk); #1; n++;
    end

    // Reset during WAIT abandons the write.
    we = 1'b1; be = MEM_SZ_WORD; addr = 32'h20; indata = 32'hCAFEF00D; cmd_v[1] = 1'b1;
    @(posedge clk); #1;
    cmd_v[1] = 1'b0;
    @(posedge clk); #1;
    check("wait_no_pulse", 32'(drdy_v[1]), 32'd0);
    rst_v[1] = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready", 32'(rdy_v[1]), 32'd0);
    check("midrst_out", out_v[1], 32'd0);
    rst_v[1] = 1'b0;
    last_out[1] = 32'h0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (drdy_v[1]) pulses++;
    end
    check("abort_pulses", 32'(pulses), 32'd0);
    xact(1, 1'b0, MEM_SZ_WORD, 32'h20, 32'h0, 1'b0, 32'h01020304);

    repeat (3) @(posedge clk);
    #1;
    check("pending_a", 32'(q_a.size()), 32'd0);
    check("pending_b", 32'(q_b.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
